// File: rtl/pg_input_stage_pkg.sv
// Shared types and defaults for the generate/propagate input stage.
package pg_input_stage_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pg_input_stage_if.sv
// Operand-in / generate-propagate-out handshake bundle.
interface pg_input_stage_if
  import pg_input_stage_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         carry_in;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic         cin_out;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  a, b, carry_in, in_valid, out_ready,
    output in_ready, g, p, cin_out, out_valid
  );

  modport master (
    output a, b, carry_in, in_valid, out_ready,
    input  in_ready, g, p, cin_out, out_valid
  );
endinterface

// File: rtl/pg_input_stage_skid_buffer.sv
// Two-entry skid buffer: output register plus one skid slot, registered in_ready.
//   state    | meaning
//   EMPTY    | nothing held
//   HALF     | output register holds an item
//   FULL     | output register and skid slot both hold items
module pg_skid_buffer
  import pg_input_stage_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = out_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_d   = in_data;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        case ({in_xfer, out_xfer})
          2'b11: out_d = in_data;
          2'b10: begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = ST_HALF;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Ready is registered from the next state, so it never depends on out_ready combinationally.
    in_ready_d = (state_d != ST_FULL);
  end

endmodule

// File: rtl/pg_input_stage.sv
// Computes bitwise generate/propagate vectors and registers them with the carry-in.
module pg_input_stage
  import pg_input_stage_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  pg_input_stage_if.slave bus
);

  localparam int W = 2 * N + 1;

  logic [W-1:0] pg_in;
  logic [W-1:0] pg_out;

  assign pg_in = {bus.a & bus.b, bus.a ^ bus.b, bus.carry_in};

  pg_skid_buffer #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (reset),
    .in_data   (pg_in),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (pg_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.g       = pg_out[2*N:N+1];
  assign bus.p       = pg_out[N:1];
  assign bus.cin_out = pg_out[0];

endmodule

// File: tb/tb_pg_input_stage.sv
// Directed and scoreboard checks of pg_input_stage at N=4 and N=8.
module tb_pg_input_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pg_input_stage_if #(.N(4)) if4 ();
  pg_input_stage_if #(.N(8)) if8 ();

  pg_input_stage #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  pg_input_stage #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0; if4.carry_in = 1'b0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.carry_in = 1'b0;
    tick();
    n_cmp++; if (if4.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", if4.in_ready); end
    n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", if4.out_valid); end
    n_cmp++; if ({if4.g, if4.p, if4.cin_out} !== 9'h0) begin n_err++; $display("FAIL rst_data: got %h want 000", {if4.g, if4.p, if4.cin_out}); end
    reset = 1'b0;
    tick();
    n_cmp++; if (if4.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise: got %b want 1", if4.in_ready); end
    n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid: got %b want 0", if4.out_valid); end
  endtask

  task automatic test_single();
    if4.a = 4'b1011; if4.b = 4'b0110; if4.carry_in = 1'b1; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    n_cmp++; if (if4.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", if4.out_valid); end
    n_cmp++; if (if4.g !== 4'b0010) begin n_err++; $display("FAIL single_g: got %b want 0010", if4.g); end
    n_cmp++; if (if4.p !== 4'b1101) begin n_err++; $display("FAIL single_p: got %b want 1101", if4.p); end
    n_cmp++; if (if4.cin_out !== 1'b1) begin n_err++; $display("FAIL single_cin: got %b want 1", if4.cin_out); end
    tick();
    n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", if4.out_valid); end
  endtask

  task automatic test_back_to_back();
    if4.out_ready = 1'b0; if4.b = 4'd0; if4.carry_in = 1'b0;
    if4.in_valid = 1'b1; if4.a = 4'd1;
    tick();
    n_cmp++; if ({if4.in_ready, if4.out_valid, if4.p} !== 6'b11_0001) begin n_err++; $display("FAIL b2b_first: got %b want 110001", {if4.in_ready, if4.out_valid, if4.p}); end
    if4.a = 4'd2;
    tick();
    n_cmp++; if ({if4.in_ready, if4.out_valid, if4.p} !== 6'b01_0001) begin n_err++; $display("FAIL b2b_full: got %b want 010001", {if4.in_ready, if4.out_valid, if4.p}); end
    if4.a = 4'd3;
    tick();
    n_cmp++; if ({if4.in_ready, if4.out_valid, if4.p, if4.g} !== 10'b01_0001_0000) begin n_err++; $display("FAIL b2b_hold: got %b want 0100010000", {if4.in_ready, if4.out_valid, if4.p, if4.g}); end
    if4.out_ready = 1'b1;
    tick();
    n_cmp++; if ({if4.in_ready, if4.out_valid, if4.p} !== 6'b11_0010) begin n_err++; $display("FAIL b2b_second: got %b want 110010", {if4.in_ready, if4.out_valid, if4.p}); end
    tick();
    if4.in_valid = 1'b0;
    n_cmp++; if ({if4.out_valid, if4.p, if4.g} !== 9'b1_0011_0000) begin n_err++; $display("FAIL b2b_third: got %b want 100110000", {if4.out_valid, if4.p, if4.g}); end
    tick();
    n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", if4.out_valid); end
  endtask

  task automatic test_stream();
    logic [3:0] ai;
    if4.out_ready = 1'b1; if4.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ai = 4'(i);
      if4.a = ai; if4.b = 4'd15 - ai; if4.carry_in = ai[0];
      tick();
      n_cmp++;
      if ({if4.in_ready, if4.out_valid, if4.g, if4.p, if4.cin_out} !== {2'b11, 4'h0, 4'hF, ai[0]}) begin
        n_err++; $display("FAIL stream_%0d: got %b want %b", i, {if4.in_ready, if4.out_valid, if4.g, if4.p, if4.cin_out}, {2'b11, 4'h0, 4'hF, ai[0]});
      end
    end
    if4.in_valid = 1'b0;
    tick();
    n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b want 0", if4.out_valid); end
  endtask

  task automatic test_reset_full();
    if4.out_ready = 1'b0; if4.in_valid = 1'b1; if4.a = 4'd5; if4.b = 4'd3; if4.carry_in = 1'b1;
    tick();
    if4.a = 4'd6; if4.b = 4'd1;
    tick();
    if4.in_valid = 1'b0;
    n_cmp++; if ({if4.in_ready, if4.out_valid} !== 2'b01) begin n_err++; $display("FAIL rf_full: got %b want 01", {if4.in_ready, if4.out_valid}); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if ({if4.out_valid, if4.in_ready, if4.g, if4.p, if4.cin_out} !== 11'b0) begin n_err++; $display("FAIL rf_async: got %b want 0", {if4.out_valid, if4.in_ready, if4.g, if4.p, if4.cin_out}); end
    tick();
    reset = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    n_cmp++; if ({if4.in_ready, if4.out_valid} !== 2'b10) begin n_err++; $display("FAIL rf_release: got %b want 10", {if4.in_ready, if4.out_valid}); end
    tick();
    n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL rf_stale: got %b want 0", if4.out_valid); end
  endtask

  task automatic test_n8();
    if8.a = 8'hFF; if8.b = 8'h01; if8.carry_in = 1'b0; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    n_cmp++; if ({if8.out_valid, if8.g, if8.p, if8.cin_out} !== {1'b1, 8'h01, 8'hFE, 1'b0}) begin n_err++; $display("FAIL n8_vector: got %h want %h", {if8.out_valid, if8.g, if8.p, if8.cin_out}, {1'b1, 8'h01, 8'hFE, 1'b0}); end
    tick();
    n_cmp++; if (if8.out_valid !== 1'b0) begin n_err++; $display("FAIL n8_drain: got %b want 0", if8.out_valid); end
  endtask

  task automatic test_random8();
    logic [16:0] q[$];
    logic [16:0] exp;
    int acc, emitted, cyc;
    acc = 0; emitted = 0; cyc = 0;
    while ((acc < 10000 || q.size() != 0) && cyc < 60000) begin
      if (acc < 10000) begin
        if8.in_valid  = ($urandom_range(0, 3) != 0);
        if8.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
      end
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.carry_in = 1'($urandom);
      if (if8.out_valid && if8.out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra: got item %h want none", {if8.g, if8.p, if8.cin_out});
        end else begin
          exp = q.pop_front();
          if ({if8.g, if8.p, if8.cin_out} !== exp) begin
            n_err++; $display("FAIL rnd_item_%0d: got %h want %h", emitted, {if8.g, if8.p, if8.cin_out}, exp);
          end
        end
        emitted++;
      end
      if (if8.in_valid && if8.in_ready) begin
        q.push_back({if8.a & if8.b, if8.a ^ if8.b, if8.carry_in});
        acc++;
      end
      tick();
      cyc++;
    end
    if8.in_valid = 1'b0;
    n_cmp++; if (emitted != 10000 || acc != 10000) begin n_err++; $display("FAIL rnd_count: got %0d out %0d in want 10000", emitted, acc); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stream();
    test_reset_full();
    test_n8();
    test_random8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
